// File: rtl/uart_tx_tl.sv
// uart_tx_tl: TileLink-UL responder that serialises CPU stores as 8N1 frames.
//
// Ports:
//   clock           - sole clock, every state update on posedge
//   tick_reset_n_in - synchronous active-low reset
//   tick_tla        - TileLink A channel (request), never back-pressured
//   bus_tld         - TileLink D channel (response), registered, one cycle per request
//   serial_tx       - serial line, idle high, registered
//   tx_busy         - transmitter FSM not idle or FIFO holding data
//
// Register map, selected by a_address[3:2]:
//   0 TXDATA : Put with a_mask[0]=1 queues a_data[7:0]; Get returns 0
//   1 STATUS : {count[12:8], fsm_busy[2], full[1], empty[0]}, read-only
//   2,3      : Get returns 0, Put ignored

package tilelink_pkg;
    localparam logic [2:0] TL_PUT_FULL        = 3'd0;
    localparam logic [2:0] TL_PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] TL_GET             = 3'd4;
    localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

    typedef struct packed {
        logic [2:0]  a_opcode;
        logic [2:0]  a_size;
        logic [3:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        a_valid;
    } tilelink_a;

    typedef struct packed {
        logic [2:0]  d_opcode;
        logic [2:0]  d_size;
        logic [3:0]  d_source;
        logic [31:0] d_data;
        logic        d_error;
        logic        d_valid;
    } tilelink_d;
endpackage

module uart_tx_tl
    import tilelink_pkg::*;
#(
    parameter logic [31:0] addr_mask      = 32'hF000000F,
    parameter logic [31:0] addr_tag       = 32'hF0000010,
    parameter int          clocks_per_bit = 4,
    parameter int          fifo_depth     = 4
) (
    input  logic      clock,
    input  logic      tick_reset_n_in,
    input  tilelink_a tick_tla,
    output tilelink_d bus_tld,
    output logic      serial_tx,
    output logic      tx_busy
);
    localparam int PW = $clog2(fifo_depth);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(clocks_per_bit);
    // The register offset bits [3:2] never take part in device selection.
    localparam logic [31:0]   SEL_MASK = addr_mask & ~32'h0000000C;
    localparam logic [CW-1:0] DEPTH    = CW'(fifo_depth);
    localparam logic [TW-1:0] T_LAST   = TW'(clocks_per_bit - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    logic [7:0]    r_mem [fifo_depth];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    tx_state_t     r_state;
    logic [TW-1:0] r_timer;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_tx;
    tilelink_d     r_tld;

    logic        w_sel;
    logic        w_is_get;
    logic        w_is_put;
    logic [1:0]  w_offset;
    logic        w_empty;
    logic        w_full;
    logic        w_push_req;
    logic        w_push;
    logic        w_pop;
    logic        w_bit_end;
    logic [31:0] w_status;
    logic        w_unused;

    // Handshake: a_ready is implicitly 1, so any cycle with a_valid and a
    // matching address is an accepted request. The D channel has no ready;
    // each accepted request yields exactly one d_valid cycle on the next clock.
    assign w_sel      = tick_tla.a_valid &&
                        ((tick_tla.a_address & SEL_MASK) == (addr_tag & SEL_MASK));
    assign w_offset   = tick_tla.a_address[3:2];
    assign w_is_get   = (tick_tla.a_opcode == TL_GET);
    assign w_is_put   = (tick_tla.a_opcode == TL_PUT_FULL) ||
                        (tick_tla.a_opcode == TL_PUT_PARTIAL);

    // Full/empty come from the registered count, so a pop in the same cycle
    // never makes room for a push.
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == DEPTH);
    assign w_push_req = w_sel && w_is_put && (w_offset == 2'd0) && tick_tla.a_mask[0];
    assign w_push     = w_push_req && !w_full;
    assign w_bit_end  = (r_timer == T_LAST);
    // Pop from IDLE, or on the final STOP cycle to chain frames without a gap.
    assign w_pop      = !w_empty && ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));

    assign w_status   = {19'd0, 5'(r_count), 5'd0, (r_state != IDLE), w_full, w_empty};
    assign w_unused   = ^{tick_tla.a_data[31:8], tick_tla.a_mask[3:1]};

    // FIFO storage carries no reset; only pointers and count do.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wptr] <= tick_tla.a_data[7:0];
        end
    end

    always_ff @(posedge clock) begin
        if (!tick_reset_n_in) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // r_tx is loaded with the level of the state being entered, so the line
    // and the state register always describe the same cycle.
    always_ff @(posedge clock) begin
        if (!tick_reset_n_in) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_timer   <= '0;
                    r_bit_idx <= '0;
                    r_tx      <= 1'b1;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rptr];
                        r_state <= START;
                        r_tx    <= 1'b0;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_timer   <= '0;
                        r_bit_idx <= '0;
                        r_state   <= DATA;
                        r_tx      <= r_shift[0];
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_timer <= '0;
                        r_shift <= {1'b0, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_timer <= '0;
                        if (w_pop) begin
                            r_shift <= r_mem[r_rptr];
                            r_state <= START;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    // Response fields are zero whenever no response is being presented.
    always_ff @(posedge clock) begin
        if (!tick_reset_n_in) begin
            r_tld <= '0;
        end else begin
            r_tld <= '0;
            if (w_sel) begin
                r_tld.d_valid  <= 1'b1;
                r_tld.d_opcode <= w_is_get ? TL_ACCESS_ACK_DATA : TL_ACCESS_ACK;
                r_tld.d_size   <= tick_tla.a_size;
                r_tld.d_source <= tick_tla.a_source;
                r_tld.d_error  <= w_push_req && w_full;
                r_tld.d_data   <= (w_is_get && (w_offset == 2'd1)) ? w_status : 32'd0;
            end
        end
    end

    assign bus_tld   = r_tld;
    assign serial_tx = r_tx;
    assign tx_busy   = (r_state != IDLE) || !w_empty;

endmodule

// File: tb/tb_uart_tx_tl.sv
module tb_uart_tx_tl;
  import tilelink_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int F     = 10 * CPB;
  // Mask widened to bits [7:4] so the neighbouring 0xF0000020 window is a different device.
  localparam logic [31:0] MASK  = 32'hF00000FF;
  localparam logic [31:0] TAG   = 32'hF0000010;
  localparam logic [31:0] SMASK = MASK & ~32'h0000000C;

  logic      clock;
  logic      rst_n;
  tilelink_a tla;
  tilelink_d tld;
  logic      serial_tx;
  logic      tx_busy;

  uart_tx_tl #(
    .addr_mask(MASK), .addr_tag(TAG), .clocks_per_bit(CPB), .fifo_depth(DEPTH)
  ) dut (
    .clock(clock), .tick_reset_n_in(rst_n), .tick_tla(tla),
    .bus_tld(tld), .serial_tx(serial_tx), .tx_busy(tx_busy)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  // ---------------- counters and check ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, m_cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The line is described per frame: a frame that begins at cycle s occupies
  // cycles s..s+F-1, with bit k = (t-s)/CPB being start, data LSB first, stop.
  int         m_cyc    = 0;
  bit         m_armed  = 0;
  bit         m_rst_q  = 0;
  bit         m_active = 0;
  int         m_fstart = 0;
  logic [7:0] m_cur    = 8'h00;
  logic [7:0] m_q[$];
  logic [7:0] exp_q[$];
  logic       exp_tx   = 1'b1;
  logic       exp_busy = 1'b0;
  tilelink_d  exp_d    = '0;

  function automatic logic frame_bit(input logic [7:0] b, input int pos);
    int k;
    k = pos / CPB;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  function automatic bit in_frame(input int t);
    return m_active && (t >= m_fstart) && (t < m_fstart + F);
  endfunction

  task automatic model_step();
    int         cnt0;
    bit         fb;
    bit         sel;
    bit         is_get;
    bit         is_put;
    bit         push_req;
    logic [1:0] off;
    if (!rst_n) begin
      m_q.delete();
      exp_q.delete();
      m_active = 0;
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
      exp_d    = '0;
      m_armed  = 1;
      m_rst_q  = 1;
    end else begin
      m_rst_q  = 0;
      cnt0     = m_q.size();
      fb       = in_frame(m_cyc);
      sel      = tla.a_valid && ((tla.a_address & SMASK) == (TAG & SMASK));
      off      = tla.a_address[3:2];
      is_get   = (tla.a_opcode == TL_GET);
      is_put   = (tla.a_opcode == TL_PUT_FULL) || (tla.a_opcode == TL_PUT_PARTIAL);
      push_req = sel && is_put && (off == 2'd0) && tla.a_mask[0];
      exp_d = '0;
      if (sel) begin
        exp_d.d_valid  = 1'b1;
        exp_d.d_opcode = is_get ? 3'd1 : 3'd0;
        exp_d.d_size   = tla.a_size;
        exp_d.d_source = tla.a_source;
        exp_d.d_error  = push_req && (cnt0 == DEPTH);
        if (is_get && off == 2'd1)
          exp_d.d_data = (cnt0 << 8) | ((fb ? 1 : 0) << 2) | ((cnt0 == DEPTH ? 1 : 0) << 1) | (cnt0 == 0 ? 1 : 0);
      end
      if (cnt0 > 0 && (!fb || m_cyc == m_fstart + F - 1)) begin
        m_cur    = m_q.pop_front();
        m_active = 1;
        m_fstart = m_cyc + 1;
      end
      if (push_req && cnt0 < DEPTH) begin
        m_q.push_back(tla.a_data[7:0]);
        exp_q.push_back(tla.a_data[7:0]);
      end
    end
    m_cyc++;
    if (rst_n) begin
      fb       = in_frame(m_cyc);
      exp_tx   = fb ? frame_bit(m_cur, m_cyc - m_fstart) : 1'b1;
      exp_busy = fb || (m_q.size() != 0);
    end
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clock);
    if (m_armed) begin
      check("serial_tx", serial_tx, exp_tx);
      check("tx_busy", tx_busy, exp_busy);
      check("d_valid", tld.d_valid, exp_d.d_valid);
      if (exp_d.d_valid) begin
        check("d_opcode", tld.d_opcode, exp_d.d_opcode);
        check("d_size", tld.d_size, exp_d.d_size);
        check("d_source", tld.d_source, exp_d.d_source);
        check("d_data", tld.d_data, exp_d.d_data);
        check("d_error", tld.d_error, exp_d.d_error);
      end
    end
  end

  // ---------------- line decoder + scoreboard ----------------
  int         frames  = 0;
  bit         dec_on  = 0;
  int         dec_cnt = 0;
  logic [7:0] dec_byte;

  initial forever begin
    int k;
    @(negedge clock);
    if (!m_armed || m_rst_q) begin
      dec_on = 0;
    end else if (!dec_on) begin
      if (serial_tx === 1'b0) begin
        dec_on  = 1;
        dec_cnt = 0;
      end
    end else begin
      dec_cnt++;
      if (dec_cnt % CPB == CPB / 2) begin
        k = dec_cnt / CPB;
        if (k == 0) begin
          check("start_bit", serial_tx, 1'b0);
        end else if (k <= 8) begin
          dec_byte[k-1] = serial_tx;
        end else begin
          check("stop_bit", serial_tx, 1'b1);
          frames++;
          check("frame_expected", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) check("tx_byte", dec_byte, exp_q.pop_front());
          dec_on = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] mask,
                        input logic [31:0] data, input logic [3:0] src, input logic [2:0] size);
    tla.a_opcode  = op;
    tla.a_size    = size;
    tla.a_source  = src;
    tla.a_address = addr;
    tla.a_mask    = mask;
    tla.a_data    = data;
    tla.a_valid   = 1'b1;
    @(negedge clock);
    tla.a_valid   = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    while (m_cyc < c) @(negedge clock);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (tx_busy !== 1'b0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    check("drain_within_bound", tx_busy, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int         n;
    int         f0;
    logic [9:0] a5_frame;
    tla   = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_serial_tx", serial_tx, 1'b1);
    check("reset_d_valid", tld.d_valid, 1'b0);
    check("reset_tx_busy", tx_busy, 1'b0);
    rst_n = 1'b1;
    do_req(TL_GET, TAG | 32'h4, 4'hF, 32'h0, 4'd3, 3'd2);
    check("reset_status", tld.d_data, 32'h00000001);
    check("reset_status_opcode", tld.d_opcode, 3'd1);

    // single byte 0xA5
    a5_frame = {1'b1, 8'hA5, 1'b0};
    n = m_cyc;
    do_req(TL_PUT_FULL, TAG, 4'h1, 32'hA5, 4'd5, 3'd0);
    check("a5_ack_valid", tld.d_valid, 1'b1);
    check("a5_ack_error", tld.d_error, 1'b0);
    check("a5_ack_source", tld.d_source, 4'd5);
    check("a5_busy_rise", tx_busy, 1'b1);
    check("a5_line_high_n1", serial_tx, 1'b1);
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < CPB; j++) begin
        wait_cyc(n + 2 + CPB * i + j);
        check("a5_frame_bit", serial_tx, a5_frame[i]);
      end
    end
    wait_cyc(n + 41);
    check("a5_busy_last_stop", tx_busy, 1'b1);
    wait_cyc(n + 42);
    check("a5_idle_n42", tx_busy, 1'b0);

    // back-to-back 0x00, 0xFF
    n = m_cyc;
    do_req(TL_PUT_FULL, TAG, 4'h1, 32'h00, 4'd1, 3'd0);
    do_req(TL_PUT_FULL, TAG, 4'h1, 32'hFF, 4'd2, 3'd0);
    wait_cyc(n + 2);
    check("b2b_first_start", serial_tx, 1'b0);
    wait_cyc(n + 41);
    check("b2b_first_stop", serial_tx, 1'b1);
    wait_cyc(n + 42);
    check("b2b_second_start", serial_tx, 1'b0);
    wait_cyc(n + 46);
    check("b2b_second_data", serial_tx, 1'b1);
    wait_idle();

    // FIFO full
    f0 = frames;
    for (int k = 0; k < 6; k++) begin
      do_req(TL_PUT_FULL, TAG, 4'h1, 32'h10 + k, 4'(k), 3'd0);
      check("full_push_error", tld.d_error, (k == 5) ? 1'b1 : 1'b0);
    end
    wait_idle();
    check("full_frame_count", frames - f0, 5);

    // mask and status
    do_req(TL_PUT_PARTIAL, TAG, 4'b1110, 32'h33, 4'd7, 3'd0);
    check("mask_ack_valid", tld.d_valid, 1'b1);
    do_req(TL_GET, TAG | 32'h4, 4'hF, 32'h0, 4'd7, 3'd2);
    check("mask_status_empty", tld.d_data, 32'h00000001);
    do_req(TL_PUT_FULL, TAG, 4'h1, 32'h41, 4'd1, 3'd0);
    do_req(TL_PUT_FULL, TAG, 4'h1, 32'h42, 4'd1, 3'd0);
    do_req(TL_PUT_FULL, TAG, 4'h1, 32'h43, 4'd1, 3'd0);
    do_req(TL_GET, TAG | 32'h4, 4'hF, 32'h0, 4'd9, 3'd2);
    check("status_two_busy", tld.d_data, 32'h00000204);
    wait_idle();

    // reset during DATA bit 3, with a request presented under reset
    n = m_cyc;
    do_req(TL_PUT_FULL, TAG, 4'h1, 32'h5A, 4'd1, 3'd0);
    do_req(TL_PUT_FULL, TAG, 4'h1, 32'h3C, 4'd1, 3'd0);
    wait_cyc(n + 19);
    rst_n = 1'b0;
    do_req(TL_PUT_FULL, TAG, 4'h1, 32'h77, 4'd1, 3'd0);
    check("midrst_line_high", serial_tx, 1'b1);
    check("midrst_not_busy", tx_busy, 1'b0);
    check("midrst_req_dropped", tld.d_valid, 1'b0);
    rst_n = 1'b1;
    f0 = frames;
    do_req(TL_GET, TAG | 32'h4, 4'hF, 32'h0, 4'd2, 3'd2);
    check("midrst_status", tld.d_data, 32'h00000001);
    repeat (60) @(negedge clock);
    check("midrst_no_frames", frames - f0, 0);

    // address decode
    do_req(TL_PUT_FULL, 32'hF0000020, 4'h1, 32'h99, 4'd2, 3'd0);
    check("decode_no_resp", tld.d_valid, 1'b0);
    check("decode_no_push", tx_busy, 1'b0);

    // randomized traffic
    for (int it = 0; it < 1500; it++) begin
      logic [2:0]  op;
      logic [31:0] addr;
      logic [1:0]  off;
      int          r;
      r  = $urandom_range(0, 8);
      op = (r < 4) ? TL_PUT_FULL : (r < 6) ? TL_PUT_PARTIAL : TL_GET;
      off = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(0, 3));
      addr = TAG | {28'd0, off, 2'b00};
      case ($urandom_range(0, 11))
        0: addr = 32'hF0000020 | {28'd0, off, 2'b00};
        1: addr = 32'h70000010;
        2: addr = 32'hF0000011;
        3: addr = $urandom();
        default: ;
      endcase
      do_req(op, addr, ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'hF,
             $urandom(), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 2)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 50)) @(negedge clock);
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clock);
        rst_n = 1'b1;
      end
    end
    wait_idle();
    repeat (5) @(negedge clock);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
